// File: rtl/sample_msg_packetizer_pkg.sv
// Shared framing constants and state encodings for sample_msg_packetizer.
// Header layout: bit WDTH-1 = header flag, bit WDTH-2 = type, [7:0] = length.
package sample_msg_packetizer_pkg;

    localparam int HDR_FLAG_OFS = 1;
    localparam int TYPE_OFS     = 2;
    localparam int LEN_W        = 8;

    localparam logic TYPE_SMP = 1'b0;
    localparam logic TYPE_MSG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHDR,
        ST_SBODY,
        ST_MBODY
    } out_st_t;

    typedef enum logic [1:0] {
        PS_EXPECT_HDR,
        PS_BODY,
        PS_DISCARD
    } prs_st_t;

endpackage

// File: rtl/sample_msg_packetizer_pkt_fifo.sv
// pkt_fifo: show-ahead synchronous FIFO with occupancy count.
// A push while full is dropped unless a pop happens on the same edge.
module pkt_fifo #(
    parameter int W     = 32,
    parameter int LOG_D = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  logic [W-1:0]   i_data,
    input  logic           i_pop,
    output logic [W-1:0]   o_data,
    output logic [LOG_D:0] o_count,
    output logic           o_full,
    output logic           o_empty
);
    localparam int D = 1 << LOG_D;

    logic [W-1:0]     r_mem [D];
    logic [LOG_D-1:0] r_wp;
    logic [LOG_D-1:0] r_rp;
    logic [LOG_D:0]   r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_cnt;
    assign o_full  = (r_cnt == (LOG_D+1)'(D));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rp];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + LOG_D'(1);
            if (w_pop)  r_rp <= r_rp + LOG_D'(1);
            r_cnt <= r_cnt + (LOG_D+1)'(w_push) - (LOG_D+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/sample_msg_packetizer.sv
// Merges a sample stream and a message stream into one tagged word stream.
// Optional short-packet flush on idle timeout: define PACKETIZER_FLUSH_EN.
module sample_msg_packetizer
    import sample_msg_packetizer_pkg::*;
#(
    parameter int WDTH          = 32,
    parameter int PKT_LEN       = 16,
    parameter int LOG_DEPTH     = 6,
    parameter int MSG_LOG_DEPTH = 4,
    parameter int FLUSH_CYCLES  = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WDTH-1:0] in_samples,
    input  logic            in_samples_nd,
    input  logic [WDTH-1:0] in_msg,
    input  logic            in_msg_nd,
    output logic [WDTH-1:0] out_data,
    output logic            out_nd,
    output logic            error
);
    localparam int MSG_DEPTH = 1 << MSG_LOG_DEPTH;
    localparam int CW        = MSG_LOG_DEPTH + 1;

    out_st_t              r_st;
    prs_st_t              r_prs;
    logic [LEN_W-1:0]     r_prem;
    logic [LEN_W-1:0]     r_plen;
    logic [LEN_W-1:0]     r_left;
    logic                 r_mhdr;
    logic                 r_last_smp;
    logic [CW-1:0]        r_done_cnt;

    logic [WDTH-1:0]      w_s_wd;
    logic [WDTH-1:0]      w_s_rd;
    logic [LOG_DEPTH:0]   w_s_cnt;
    logic                 w_s_full;
    logic                 w_s_empty;
    logic                 w_s_pop;
    logic [WDTH-1:0]      w_m_rd;
    logic [MSG_LOG_DEPTH:0] w_m_cnt;
    logic                 w_m_full;
    logic                 w_m_empty;
    logic                 w_m_pop;
    logic                 w_m_push;
    logic                 w_is_hdr;
    logic [LEN_W-1:0]     w_len;
    logic                 w_fits;
    logic                 w_m_done;
    logic                 w_m_end;
    logic                 w_prs_err;
    logic                 w_smp_full;
    logic                 w_smp_rdy;
    logic                 w_msg_rdy;
    logic                 w_flush_hit;
    logic [WDTH-1:0]      w_shdr;
    logic                 w_unused_tag;

    assign w_unused_tag = ^in_samples[WDTH-1:WDTH-2];
    assign w_s_wd  = {2'b00, in_samples[WDTH-3:0]};
    assign w_s_pop = (r_st == ST_SBODY) && !w_s_empty;
    assign w_m_pop = (r_st == ST_MBODY) && !w_m_empty;

    pkt_fifo #(.W(WDTH), .LOG_D(LOG_DEPTH)) u_smp_fifo (
        .clk(clk), .rst_n(rst_n),
        .i_push(in_samples_nd), .i_data(w_s_wd), .i_pop(w_s_pop),
        .o_data(w_s_rd), .o_count(w_s_cnt),
        .o_full(w_s_full), .o_empty(w_s_empty)
    );

    pkt_fifo #(.W(WDTH), .LOG_D(MSG_LOG_DEPTH)) u_msg_fifo (
        .clk(clk), .rst_n(rst_n),
        .i_push(w_m_push), .i_data(in_msg), .i_pop(w_m_pop),
        .o_data(w_m_rd), .o_count(w_m_cnt),
        .o_full(w_m_full), .o_empty(w_m_empty)
    );

    assign w_is_hdr = in_msg[WDTH-HDR_FLAG_OFS] &&
                      (in_msg[WDTH-TYPE_OFS] == TYPE_MSG);
    assign w_len    = in_msg[LEN_W-1:0];
    assign w_fits   = (int'(w_len) + 1) <= MSG_DEPTH;

    assign w_m_push = in_msg_nd &&
        ((r_prs == PS_BODY) ||
         ((r_prs == PS_EXPECT_HDR) && w_is_hdr && w_fits));
    assign w_m_done = in_msg_nd &&
        (((r_prs == PS_EXPECT_HDR) && w_is_hdr && w_fits && (w_len == '0)) ||
         ((r_prs == PS_BODY) && (r_prem == LEN_W'(1))));
    assign w_prs_err = in_msg_nd && (r_prs == PS_EXPECT_HDR) &&
                       (!w_is_hdr || !w_fits);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prs  <= PS_EXPECT_HDR;
            r_prem <= '0;
        end else if (in_msg_nd) begin
            unique case (r_prs)
                PS_EXPECT_HDR: begin
                    if (w_is_hdr && (w_len != '0)) begin
                        r_prs  <= w_fits ? PS_BODY : PS_DISCARD;
                        r_prem <= w_len;
                    end
                end
                PS_BODY, PS_DISCARD: begin
                    r_prem <= r_prem - LEN_W'(1);
                    if (r_prem == LEN_W'(1)) r_prs <= PS_EXPECT_HDR;
                end
                default: r_prs <= PS_EXPECT_HDR;
            endcase
        end
    end

    assign w_smp_full = int'(w_s_cnt) >= PKT_LEN;
    assign w_smp_rdy  = w_smp_full || w_flush_hit;
    assign w_msg_rdy  = (r_done_cnt != '0) && (w_m_cnt != '0);
    assign w_m_end    = (r_st == ST_MBODY) && !w_m_empty &&
        ((r_mhdr && (w_m_rd[LEN_W-1:0] == '0)) ||
         (!r_mhdr && (r_left == LEN_W'(1))));

`ifdef PACKETIZER_FLUSH_EN
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    logic [FW-1:0] r_flush;
    logic          w_flush_cond;

    assign w_flush_cond = (r_st == ST_IDLE) && !in_samples_nd &&
                          (w_s_cnt != '0) && !w_smp_full;
    assign w_flush_hit  = int'(r_flush) == FLUSH_CYCLES;

    // Holds its value outside IDLE so a pending flush survives a message.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush <= '0;
        end else if (in_samples_nd || (r_st == ST_SHDR)) begin
            r_flush <= '0;
        end else if (w_flush_cond && !w_flush_hit) begin
            r_flush <= r_flush + FW'(1);
        end
    end
`else
    localparam int UNUSED_FLUSH = FLUSH_CYCLES;
    assign w_flush_hit = 1'b0;
`endif

    always_comb begin
        w_shdr = '0;
        w_shdr[WDTH-HDR_FLAG_OFS] = 1'b1;
        w_shdr[WDTH-TYPE_OFS]     = TYPE_SMP;
        w_shdr[LEN_W-1:0]         = r_plen;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
            error      <= 1'b0;
        end else begin
            r_done_cnt <= r_done_cnt + CW'(w_m_done) - CW'(w_m_end);
            if (w_prs_err ||
                (in_samples_nd && w_s_full && !w_s_pop) ||
                (w_m_push && w_m_full && !w_m_pop))
                error <= 1'b1;
        end
    end

    // Reset value of r_last_smp lets a message win the very first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st       <= ST_IDLE;
            r_plen     <= '0;
            r_left     <= '0;
            r_mhdr     <= 1'b0;
            r_last_smp <= 1'b1;
            out_data   <= '0;
            out_nd     <= 1'b0;
        end else begin
            unique case (r_st)
                ST_IDLE: begin
                    out_nd <= 1'b0;
                    if (w_msg_rdy && (r_last_smp || !w_smp_rdy)) begin
                        r_st   <= ST_MBODY;
                        r_mhdr <= 1'b1;
                    end else if (w_smp_rdy) begin
                        r_st   <= ST_SHDR;
                        r_plen <= w_smp_full ? LEN_W'(PKT_LEN)
                                             : LEN_W'(w_s_cnt);
                    end
                end
                ST_SHDR: begin
                    out_data   <= w_shdr;
                    out_nd     <= 1'b1;
                    r_left     <= r_plen;
                    r_last_smp <= 1'b1;
                    r_st       <= ST_SBODY;
                end
                ST_SBODY: begin
                    out_data <= w_s_rd;
                    out_nd   <= 1'b1;
                    r_left   <= r_left - LEN_W'(1);
                    if (r_left == LEN_W'(1)) r_st <= ST_IDLE;
                end
                ST_MBODY: begin
                    out_data <= w_m_rd;
                    out_nd   <= 1'b1;
                    r_mhdr   <= 1'b0;
                    r_left   <= r_mhdr ? w_m_rd[LEN_W-1:0]
                                       : r_left - LEN_W'(1);
                    if (w_m_end) begin
                        r_st       <= ST_IDLE;
                        r_last_smp <= 1'b0;
                    end
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

endmodule
